// File: rtl/ov7670_capture_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ov7670_pkg
// Description : Shared definitions for the OV7670 RGB444 capture block:
//               capture FSM state encoding, default frame-buffer depth and
//               the RGB444 bit-field positions of the camera bytes and of the
//               12-bit assembled pixel.
// Revision    : 1.0 - initial release
// ============================================================================
package ov7670_pkg;

    // Default frame buffer: 320 x 240 pixels
    localparam int c_fb_depth_default = 76800;

    // Capture FSM encoding
    typedef enum logic [1:0] {
        ST_WAIT_VS_HIGH = 2'd0,
        ST_WAIT_VS_LOW  = 2'd1,
        ST_ACTIVE       = 2'd2
    } state_t;

    // Byte 0 carries {xxxx, R[3:0]}; byte 1 carries {G[3:0], B[3:0]}
    localparam int c_b0_r_msb = 3;
    localparam int c_b0_r_lsb = 0;
    localparam int c_b1_g_msb = 7;
    localparam int c_b1_g_lsb = 4;
    localparam int c_b1_b_msb = 3;
    localparam int c_b1_b_lsb = 0;

    // Assembled pixel {R, G, B}
    localparam int c_pix_r_msb = 11;
    localparam int c_pix_r_lsb = 8;
    localparam int c_pix_g_msb = 7;
    localparam int c_pix_g_lsb = 4;
    localparam int c_pix_b_msb = 3;
    localparam int c_pix_b_lsb = 0;

endpackage : ov7670_pkg
`default_nettype wire

// File: rtl/ov7670_capture_byte_pair.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_byte_pair
// Description : Pairs the two RGB444 camera bytes of each pixel. A phase bit
//               toggles on every href cycle while enabled, starting at 0 on
//               the first byte of each line. Phase 0 latches R, phase 1
//               presents the assembled {R,G,B} pixel with a completion strobe
//               that the caller registers. A dangling odd byte at line end
//               is dropped because the phase clears whenever href is low.
// Ports       : clk        - pixel clock
//               rst        - synchronous active-high reset
//               i_en       - capture window open (FSM in ACTIVE)
//               i_href_q   - registered line-valid
//               i_d_q      - registered camera byte
//               o_pix_done - pixel completes on this cycle (combinational)
//               o_pix      - assembled 12-bit pixel, valid with o_pix_done
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_byte_pair
    import ov7670_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_href_q,
    input  logic [7:0]  i_d_q,
    output logic        o_pix_done,
    output logic [11:0] o_pix
);

    logic       r_phase;
    logic [3:0] r_red;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= 1'b0;
            r_red   <= 4'd0;
        end else if (!i_en || !i_href_q) begin
            // Outside a line the phase parks at 0 so the next line starts
            // on byte 0 and any unpaired trailing byte is forgotten.
            r_phase <= 1'b0;
        end else begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
                r_red <= i_d_q[c_b0_r_msb:c_b0_r_lsb];
            end
        end
    end

    assign o_pix_done = i_en & i_href_q & r_phase;
    assign o_pix      = {r_red, i_d_q};

endmodule : ov7670_byte_pair
`default_nettype wire

// File: rtl/ov7670_capture.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_capture
// Description : OV7670 RGB444 frame grabber. Registers the camera pins once,
//               tracks frame boundaries with a vsync FSM, assembles pixels
//               via ov7670_byte_pair and issues frame-buffer writes with a
//               linear address that restarts at 0 every frame. Pixels beyond
//               FB_DEPTH are dropped and flagged by a sticky overflow.
// Ports       : clk        - camera pixel clock (PCLK)
//               reset      - synchronous active-high reset
//               vsync      - frame sync, high between frames
//               href       - line valid
//               d[7:0]     - camera data byte
//               addr       - frame-buffer write address
//               dout[11:0] - {R,G,B} 4:4:4 write data
//               we         - write enable, one pulse per stored pixel
//               frame_done - one-cycle pulse at end of each captured frame
//               overflow   - sticky, frame had more than FB_DEPTH pixels
// Options     : OV7670_CAPTURE_DECIMATE_EN - VGA input, keep only even
//               pixels of even lines (2:1 in each direction).
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int FB_DEPTH = c_fb_depth_default,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        d,
    output logic [ADDR_W-1:0] addr,
    output logic [11:0]       dout,
    output logic              we,
    output logic              frame_done,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FB_DEPTH - 1);

    logic        r_vsync_q;
    logic        r_href_q;
    logic [7:0]  r_d_q;
    state_t      r_state;
    logic        r_full;         // last address already written this frame
    logic        r_end_pending;  // frame end deferred behind a final write

    logic        w_en;
    logic        w_pix_done;
    logic [11:0] w_pix;
    logic        w_keep;
    logic        w_wr;

    // ------------------------------------------------------------------
    // Input registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vsync_q <= 1'b0;
            r_href_q  <= 1'b0;
            r_d_q     <= 8'd0;
        end else begin
            r_vsync_q <= vsync;
            r_href_q  <= href;
            r_d_q     <= d;
        end
    end

    assign w_en = (r_state == ST_ACTIVE);

    ov7670_byte_pair u_byte_pair (
        .clk        (clk),
        .rst        (reset),
        .i_en       (w_en),
        .i_href_q   (r_href_q),
        .i_d_q      (r_d_q),
        .o_pix_done (w_pix_done),
        .o_pix      (w_pix)
    );

`ifdef OV7670_CAPTURE_DECIMATE_EN
    // Keep bits are 1 on even pixels / even lines.
    logic r_href_d;
    logic r_pix_keep;
    logic r_line_keep;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_href_d    <= 1'b0;
            r_pix_keep  <= 1'b1;
            r_line_keep <= 1'b1;
        end else begin
            r_href_d <= r_href_q;
            if (!w_en) begin
                r_pix_keep  <= 1'b1;
                r_line_keep <= 1'b1;
            end else begin
                if (r_href_q && !r_href_d) begin
                    r_pix_keep <= 1'b1;
                end else if (w_pix_done) begin
                    r_pix_keep <= ~r_pix_keep;
                end
                if (!r_href_q && r_href_d) begin
                    r_line_keep <= ~r_line_keep;
                end
            end
        end
    end

    assign w_keep = r_pix_keep & r_line_keep;
`else
    assign w_keep = 1'b1;
`endif

    assign w_wr = w_pix_done & w_keep;

    // ------------------------------------------------------------------
    // Frame FSM, addressing and write generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_WAIT_VS_HIGH;
            addr          <= '0;
            dout          <= 12'd0;
            we            <= 1'b0;
            frame_done    <= 1'b0;
            overflow      <= 1'b0;
            r_full        <= 1'b0;
            r_end_pending <= 1'b0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;

            // Address advances the cycle after a write; it parks on the
            // last location once the buffer is full.
            if (we) begin
                if (addr == c_last_addr) begin
                    r_full <= 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end

            if (w_wr) begin
                if (r_full) begin
                    overflow <= 1'b1;
                end else begin
                    we   <= 1'b1;
                    dout <= w_pix;
                end
            end

            // Deferred frame end: placed after the address update so the
            // reload to 0 takes precedence over the post-write increment.
            if (r_end_pending) begin
                r_end_pending <= 1'b0;
                frame_done    <= 1'b1;
                addr          <= '0;
                overflow      <= 1'b0;
                r_full        <= 1'b0;
            end

            case (r_state)
                ST_WAIT_VS_HIGH: begin
                    if (r_vsync_q) r_state <= ST_WAIT_VS_LOW;
                end
                ST_WAIT_VS_LOW: begin
                    if (!r_vsync_q) r_state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (r_vsync_q) begin
                        r_state <= ST_WAIT_VS_LOW;
                        if (w_wr && !r_full) begin
                            // A final pixel lands on this edge: let it write
                            // at its own address, close the frame next cycle.
                            r_end_pending <= 1'b1;
                        end else begin
                            frame_done <= 1'b1;
                            addr       <= '0;
                            overflow   <= 1'b0;
                            r_full     <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_WAIT_VS_HIGH;
            endcase
        end
    end

endmodule : ov7670_capture
`default_nettype wire
